regbank_write_scheduler: RTL

REGBANK_WRITE_SCHEDULER -- requirements
Module: regbank_write_scheduler

---
 rtl/regbank_write_scheduler_pkg.sv | 29 ++
 rtl/rr_arbiter3.sv | 32 +++
 rtl/regbank_write_scheduler.sv | 117 +++++++++++
 3 files changed

// File: rtl/regbank_write_scheduler_pkg.sv
// Shared types and constants for the register-bank write scheduler.
// Holds the FSM encoding, the requester indices and the default widths.
package regbank_write_scheduler_pkg;

    localparam int unsigned DefaultDataWidth = 32;
    localparam int unsigned DefaultAddrWidth = 5;

    localparam logic [1:0] ReqAlu  = 2'd0;
    localparam logic [1:0] ReqLoad = 2'd1;
    localparam logic [1:0] ReqLink = 2'd2;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StStrobe = 2'd2,
        StHold   = 2'd3
    } state_e;

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        case (oh)
            3'b010:  idx = ReqLoad;
            3'b100:  idx = ReqLink;
            default: idx = ReqAlu;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: the search starts at the requester after the
// last one granted, so a requester is never granted twice while another waits.
module rr_arbiter3
    import regbank_write_scheduler_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] last_i,
    output logic [2:0] grant_o
);

    always_comb begin
        grant_o = 3'b000;
        case (last_i)
            ReqAlu: begin
                if (req_i[1])      grant_o = 3'b010;
                else if (req_i[2]) grant_o = 3'b100;
                else if (req_i[0]) grant_o = 3'b001;
            end
            ReqLoad: begin
                if (req_i[2])      grant_o = 3'b100;
                else if (req_i[0]) grant_o = 3'b001;
                else if (req_i[1]) grant_o = 3'b010;
            end
            default: begin
                if (req_i[0])      grant_o = 3'b001;
                else if (req_i[1]) grant_o = 3'b010;
                else if (req_i[2]) grant_o = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/regbank_write_scheduler.sv
// Serialises ALU/Load/Link writes into the register bank with a fixed
// SETUP/STROBE/HOLD pulse sequence and counts committed writes.
module regbank_write_scheduler
    import regbank_write_scheduler_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [2:0]            Req,
    input  logic [ADDR_WIDTH-1:0] ReqRegister0,
    input  logic [ADDR_WIDTH-1:0] ReqRegister1,
    input  logic [ADDR_WIDTH-1:0] ReqRegister2,
    input  logic [DATA_WIDTH-1:0] ReqData0,
    input  logic [DATA_WIDTH-1:0] ReqData1,
    input  logic [DATA_WIDTH-1:0] ReqData2,
    output logic [2:0]            Grant,
    output logic [ADDR_WIDTH-1:0] WriteRegister,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  RegWrite,
    output logic                  Busy,
    output logic [15:0]           WriteCount
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_reg_q, wr_reg_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  zero_q, zero_d;
    logic [1:0]            last_q, last_d;
    logic [15:0]           count_q, count_d;
    logic [2:0]            arb_grant;
    logic                  granted;

    rr_arbiter3 u_arbiter (
        .req_i   (Req),
        .last_i  (last_q),
        .grant_o (arb_grant)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (granted) state_d = StSetup;
            StSetup:  state_d = StStrobe;
            StStrobe: state_d = StHold;
            StHold:   state_d = granted ? StSetup : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Grant is masked by Reset so it drops immediately, not at the next edge.
    always_comb begin
        Grant = 3'b000;
        if (!Reset && (state_q == StIdle || state_q == StHold) && (Req != 3'b000)) begin
            Grant = arb_grant;
        end
        RegWrite      = (state_q == StStrobe) && !zero_q;
        Busy          = (state_q != StIdle);
        WriteRegister = wr_reg_q;
        WriteData     = wr_data_q;
        WriteCount    = count_q;
    end

    assign granted = (Grant != 3'b000);

    always_comb begin
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        zero_d    = zero_q;
        last_d    = last_q;
        if (granted) begin
            unique case (Grant)
                3'b010: begin
                    wr_reg_d  = ReqRegister1;
                    wr_data_d = ReqData1;
                end
                3'b100: begin
                    wr_reg_d  = ReqRegister2;
                    wr_data_d = ReqData2;
                end
                default: begin
                    wr_reg_d  = ReqRegister0;
                    wr_data_d = ReqData0;
                end
            endcase
            zero_d = (wr_reg_d == '0);
            last_d = onehot_to_idx(Grant);
        end
        count_d = count_q + {15'd0, RegWrite};
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            zero_q    <= 1'b0;
            last_q    <= ReqLink;
            count_q   <= 16'd0;
        end else begin
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            zero_q    <= zero_d;
            last_q    <= last_d;
            count_q   <= count_d;
        end
    end

endmodule
